// File: rtl/exe_mem_pipe_reg_if.sv
// exe_mem_pipe_reg_if: EXE->MEM pipeline bundle.
// Carries the incoming EXE-stage fields, the stage controls (freeze/flush),
// the store-value forwarding sources/selector, and the registered MEM-stage
// outputs plus the stall counter.
// master: EXE-side driver (drives *_in, controls and forwarding data).
// slave : the pipeline register (consumes inputs, drives registered outputs).
interface exe_mem_pipe_reg_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEST_W  = 5,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  // stage controls and incoming instruction
  logic                      freeze;
  logic                      flush;
  logic                      valid_in;
  logic                      wb_en_in;
  logic                      mem_r_en_in;
  logic                      mem_w_en_in;
  logic [DATA_W-1:0]         pc_in;
  logic [DATA_W-1:0]         alu_result_in;
  logic [DATA_W-1:0]         st_val_in;
  logic [DEST_W-1:0]         dest_in;
  logic [SEL_W-1:0]          st_val_sel;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;

  // registered MEM-stage view
  logic                      valid;
  logic                      wb_en;
  logic                      mem_r_en;
  logic                      mem_w_en;
  logic [DATA_W-1:0]         pc;
  logic [DATA_W-1:0]         alu_result;
  logic [DATA_W-1:0]         st_val;
  logic [DEST_W-1:0]         dest;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in,
           pc_in, alu_result_in, st_val_in, dest_in, st_val_sel, fwd_data,
    input  valid, wb_en, mem_r_en, mem_w_en, pc, alu_result, st_val, dest,
           stall_cnt
  );

  modport slave (
    input  freeze, flush, valid_in, wb_en_in, mem_r_en_in, mem_w_en_in,
           pc_in, alu_result_in, st_val_in, dest_in, st_val_sel, fwd_data,
    output valid, wb_en, mem_r_en, mem_w_en, pc, alu_result, st_val, dest,
           stall_cnt
  );
endinterface

// File: rtl/exe_mem_pipe_reg.sv
// exe_mem_pipe_reg: EXE->MEM pipeline register with store-value forwarding
// mux, valid bit, flush (bubble) and freeze (stall) handling.
// While frozen, the forwarded store value is captured once into a shadow
// register, since later-stage forwarding sources keep moving during the stall.
// Also keeps a saturating count of frozen cycles.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-high reset
//   bus  - exe_mem_pipe_reg_if.slave (inputs, controls, registered outputs)
module exe_mem_pipe_reg #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned DEST_W  = 5,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  exe_mem_pipe_reg_if.slave        bus
);
  localparam int unsigned SEL_W = $clog2(NUM_FWD + 1);

  logic              valid_q,    valid_d;
  logic              wb_en_q,    wb_en_d;
  logic              mem_r_en_q, mem_r_en_d;
  logic              mem_w_en_q, mem_w_en_d;
  logic [DATA_W-1:0] pc_q,       pc_d;
  logic [DATA_W-1:0] alu_q,      alu_d;
  logic [DATA_W-1:0] st_val_q,   st_val_d;
  logic [DEST_W-1:0] dest_q,     dest_d;
  logic [DATA_W-1:0] shadow_q,   shadow_d;
  logic              shadow_vld_q, shadow_vld_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [DATA_W-1:0] chosen_c;

  // Store-value mux; out-of-range selectors fall back to the register-file value.
  always_comb begin
    chosen_c = bus.st_val_in;
    for (int unsigned k = 1; k <= NUM_FWD; k++) begin
      if (bus.st_val_sel == SEL_W'(k)) begin
        chosen_c = bus.fwd_data[(k-1)*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state: flush > freeze > load.
  always_comb begin
    valid_d      = valid_q;
    wb_en_d      = wb_en_q;
    mem_r_en_d   = mem_r_en_q;
    mem_w_en_d   = mem_w_en_q;
    pc_d         = pc_q;
    alu_d        = alu_q;
    st_val_d     = st_val_q;
    dest_d       = dest_q;
    shadow_d     = shadow_q;
    shadow_vld_d = shadow_vld_q;
    stall_cnt_d  = stall_cnt_q;

    if (bus.flush) begin
      valid_d      = 1'b0;
      wb_en_d      = 1'b0;
      mem_r_en_d   = 1'b0;
      mem_w_en_d   = 1'b0;
      pc_d         = '0;
      alu_d        = '0;
      st_val_d     = '0;
      dest_d       = '0;
      shadow_vld_d = 1'b0;
    end else if (bus.freeze) begin
      // Capture only on the first frozen edge; later source changes are ignored.
      if (!shadow_vld_q) begin
        shadow_d     = chosen_c;
        shadow_vld_d = 1'b1;
      end
      if (stall_cnt_q != '1) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end else begin
      valid_d      = bus.valid_in;
      wb_en_d      = bus.wb_en_in;
      mem_r_en_d   = bus.mem_r_en_in;
      mem_w_en_d   = bus.mem_w_en_in;
      pc_d         = bus.pc_in;
      alu_d        = bus.alu_result_in;
      st_val_d     = shadow_vld_q ? shadow_q : chosen_c;
      dest_d       = bus.dest_in;
      shadow_vld_d = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      wb_en_q      <= 1'b0;
      mem_r_en_q   <= 1'b0;
      mem_w_en_q   <= 1'b0;
      pc_q         <= '0;
      alu_q        <= '0;
      st_val_q     <= '0;
      dest_q       <= '0;
      shadow_q     <= '0;
      shadow_vld_q <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      valid_q      <= valid_d;
      wb_en_q      <= wb_en_d;
      mem_r_en_q   <= mem_r_en_d;
      mem_w_en_q   <= mem_w_en_d;
      pc_q         <= pc_d;
      alu_q        <= alu_d;
      st_val_q     <= st_val_d;
      dest_q       <= dest_d;
      shadow_q     <= shadow_d;
      shadow_vld_q <= shadow_vld_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  assign bus.valid      = valid_q;
  assign bus.wb_en      = wb_en_q;
  assign bus.mem_r_en   = mem_r_en_q;
  assign bus.mem_w_en   = mem_w_en_q;
  assign bus.pc         = pc_q;
  assign bus.alu_result = alu_q;
  assign bus.st_val     = st_val_q;
  assign bus.dest       = dest_q;
  assign bus.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_exe_mem_pipe_reg.sv
// Self-checking bench for exe_mem_pipe_reg: table vectors, directed
// multi-cycle sequences and random stimulus against a behavioural model.
// A second instance with a 4-bit stall counter exercises saturation.
module tb_exe_mem_pipe_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_mem_pipe_reg_if #(.DATA_W(32), .DEST_W(5), .NUM_FWD(2), .CNT_W(16)) bus ();
  exe_mem_pipe_reg_if #(.DATA_W(32), .DEST_W(5), .NUM_FWD(2), .CNT_W(4))  bus4 ();

  exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(5), .NUM_FWD(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave));
  exe_mem_pipe_reg #(.DATA_W(32), .DEST_W(5), .NUM_FWD(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus4.slave));

  int vec_cnt = 0;
  int err_cnt = 0;

  // behavioural model of the visible stage state
  logic        m_valid, m_wb, m_mr, m_mw;
  logic [31:0] m_pc, m_alu, m_st;
  logic [4:0]  m_dest;
  int          m_cnt;
  bit          m_held;
  logic [31:0] m_held_val;

  typedef struct {
    logic [31:0] pc, alu, st, f0, f1;
    logic [4:0]  dest;
    logic [1:0]  sel;
    logic        vin, wb, mr, mw;
    logic [31:0] exp_st;
  } vec_t;
  vec_t tbl[5];

  function automatic vec_t mk(logic [31:0] pc, logic [31:0] alu, logic [31:0] st,
                              logic [31:0] f0, logic [31:0] f1, logic [4:0] dest,
                              logic [1:0] sel, logic vin, logic wb, logic mr,
                              logic mw, logic [31:0] exp_st);
    vec_t v;
    v.pc = pc; v.alu = alu; v.st = st; v.f0 = f0; v.f1 = f1; v.dest = dest;
    v.sel = sel; v.vin = vin; v.wb = wb; v.mr = mr; v.mw = mw; v.exp_st = exp_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Value the store port would carry if loaded now, from the selector rules.
  function automatic logic [31:0] pick();
    int s = int'(bus.st_val_sel);
    if (s == 0 || s > 2) return bus.st_val_in;
    return 32'(bus.fwd_data >> (32 * (s - 1)));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
    m_pc = 0; m_alu = 0; m_st = 0; m_dest = 0;
    m_cnt = 0; m_held = 0; m_held_val = 0;
  endtask

  task automatic model_step();
    logic [31:0] ch = pick();
    if (bus.flush) begin
      m_valid = 0; m_wb = 0; m_mr = 0; m_mw = 0;
      m_pc = 0; m_alu = 0; m_st = 0; m_dest = 0;
      m_held = 0;
    end else if (bus.freeze) begin
      if (!m_held) begin m_held = 1; m_held_val = ch; end
      if (m_cnt < 65535) m_cnt++;
    end else begin
      m_valid = bus.valid_in; m_wb = bus.wb_en_in;
      m_mr = bus.mem_r_en_in; m_mw = bus.mem_w_en_in;
      m_pc = bus.pc_in; m_alu = bus.alu_result_in; m_dest = bus.dest_in;
      m_st = m_held ? m_held_val : ch;
      m_held = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".valid"},     bus.valid,      m_valid);
    chk({tag, ".wb_en"},     bus.wb_en,      m_wb);
    chk({tag, ".mem_r_en"},  bus.mem_r_en,   m_mr);
    chk({tag, ".mem_w_en"},  bus.mem_w_en,   m_mw);
    chk({tag, ".pc"},        bus.pc,         m_pc);
    chk({tag, ".alu"},       bus.alu_result, m_alu);
    chk({tag, ".st_val"},    bus.st_val,     m_st);
    chk({tag, ".dest"},      bus.dest,       m_dest);
    chk({tag, ".stall_cnt"}, bus.stall_cnt,  64'(m_cnt));
  endtask

  // One clock edge: model follows the inputs presented at the edge; sample at negedge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic set_in(input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] st, input logic [4:0] dest,
                        input logic [1:0] sel, input logic vin, input logic wb,
                        input logic mr, input logic mw);
    bus.pc_in = pc; bus.alu_result_in = alu; bus.st_val_in = st; bus.dest_in = dest;
    bus.st_val_sel = sel; bus.valid_in = vin; bus.wb_en_in = wb;
    bus.mem_r_en_in = mr; bus.mem_w_en_in = mw;
  endtask

  initial begin
    logic [31:0] rst_pc;
    int cnt0;

    bus.freeze = 0; bus.flush = 0; bus.fwd_data = '0;
    set_in(32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus4.freeze = 0; bus4.flush = 0; bus4.valid_in = 0; bus4.wb_en_in = 0;
    bus4.mem_r_en_in = 0; bus4.mem_w_en_in = 0; bus4.pc_in = 0;
    bus4.alu_result_in = 0; bus4.st_val_in = 0; bus4.dest_in = 0;
    bus4.st_val_sel = 0; bus4.fwd_data = '0;
    model_reset();

    // reset state (held in reset across an edge)
    @(posedge clk);
    @(negedge clk);
    check_model("reset");
    rst = 1'b0;

    // table-driven loads
    tbl[0] = mk(32'h40, 32'h1234, 32'hAA, 32'h11, 32'h22, 5'd7, 2'd0, 1, 1, 0, 0, 32'hAA);
    tbl[1] = mk(32'h44, 32'h10,   32'hBB, 32'h11, 32'h22, 5'd3, 2'd2, 1, 0, 0, 1, 32'h22);
    tbl[2] = mk(32'h48, 32'h20,   32'hBB, 32'h11, 32'h22, 5'd4, 2'd1, 1, 0, 1, 0, 32'h11);
    tbl[3] = mk(32'h4C, 32'h30,   32'hCC, 32'h11, 32'h22, 5'd5, 2'd3, 1, 1, 0, 0, 32'hCC);
    tbl[4] = mk(32'h50, 32'h40,   32'hDD, 32'h33, 32'h44, 5'd31, 2'd0, 0, 1, 1, 1, 32'hDD);
    for (int i = 0; i < 5; i++) begin
      set_in(tbl[i].pc, tbl[i].alu, tbl[i].st, tbl[i].dest, tbl[i].sel,
             tbl[i].vin, tbl[i].wb, tbl[i].mr, tbl[i].mw);
      bus.fwd_data = {tbl[i].f1, tbl[i].f0};
      tick();
      chk($sformatf("tbl%0d.pc", i),     bus.pc,         tbl[i].pc);
      chk($sformatf("tbl%0d.alu", i),    bus.alu_result, tbl[i].alu);
      chk($sformatf("tbl%0d.st_val", i), bus.st_val,     tbl[i].exp_st);
      chk($sformatf("tbl%0d.dest", i),   bus.dest,       tbl[i].dest);
      chk($sformatf("tbl%0d.valid", i),  bus.valid,      tbl[i].vin);
      chk($sformatf("tbl%0d.wb_en", i),  bus.wb_en,      tbl[i].wb);
      chk($sformatf("tbl%0d.mem_r", i),  bus.mem_r_en,   tbl[i].mr);
      chk($sformatf("tbl%0d.mem_w", i),  bus.mem_w_en,   tbl[i].mw);
      chk($sformatf("tbl%0d.cnt", i),    bus.stall_cnt,  64'd0);
    end

    // stall capture: three frozen edges, slice0 keeps moving
    cnt0 = m_cnt;
    set_in(32'h60, 32'h600, 32'hEE, 5'd9, 2'd1, 1, 1, 0, 1);
    bus.freeze = 1;
    for (int i = 0; i < 3; i++) begin
      bus.fwd_data = {32'h22, 32'(32'h100 * (i + 1))};
      tick();
      chk("stall.hold_pc", bus.pc,     tbl[4].pc);
      chk("stall.hold_st", bus.st_val, tbl[4].exp_st);
      check_model("stall");
    end
    bus.freeze = 0;
    bus.fwd_data = {32'h22, 32'h400};
    bus.st_val_sel = 2'd2;  // selector change after capture must not matter
    tick();
    chk("stall.st_val", bus.st_val, 32'h100);
    chk("stall.pc", bus.pc, 32'h60);
    chk("stall.cnt", bus.stall_cnt, 64'(cnt0 + 3));
    check_model("stall_load");

    // flush with freeze: bubble, no capture, no count
    cnt0 = m_cnt;
    set_in(32'h70, 32'h700, 32'h77, 5'd2, 2'd1, 1, 1, 0, 1);
    bus.freeze = 1; bus.flush = 1;
    bus.fwd_data = {32'h22, 32'h500};
    tick();
    chk("flush.valid", bus.valid, 1'b0);
    chk("flush.wb_en", bus.wb_en, 1'b0);
    chk("flush.mem_w", bus.mem_w_en, 1'b0);
    chk("flush.pc", bus.pc, 32'h0);
    chk("flush.st_val", bus.st_val, 32'h0);
    chk("flush.cnt", bus.stall_cnt, 64'(cnt0));
    bus.freeze = 0; bus.flush = 0;
    bus.fwd_data = {32'h22, 32'h555};
    tick();
    chk("post_flush.st_val", bus.st_val, 32'h555);
    check_model("post_flush");

    // freeze for exactly one edge
    bus.freeze = 1; bus.fwd_data = {32'h22, 32'hABC};
    tick();
    bus.freeze = 0; bus.fwd_data = {32'h22, 32'hDEF};
    tick();
    chk("one_freeze.st_val", bus.st_val, 32'hABC);
    check_model("one_freeze");

    // async reset between edges, mid-freeze with shadow captured
    bus.freeze = 1; bus.fwd_data = {32'h22, 32'h777};
    tick();
    rst_pc = bus.pc;
    chk("pre_rst.pc_nonzero", 64'(rst_pc != 0), 64'd1);
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    bus.freeze = 0; bus.fwd_data = {32'h22, 32'h888};
    tick();
    chk("post_rst.st_val", bus.st_val, 32'h888);
    check_model("post_rst");

    // saturation of a 4-bit stall counter (also keeps the main model ticking)
    bus4.freeze = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("sat.cnt%0d", i), bus4.stall_cnt, 64'((i > 15) ? 15 : i));
    end
    bus4.freeze = 0;
    check_model("sat_main");

    // random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      set_in($urandom, $urandom, $urandom, 5'($urandom), 2'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      bus.fwd_data = {$urandom, $urandom};
      bus.freeze = ($urandom_range(0, 9) < 4);
      bus.flush  = ($urandom_range(0, 9) == 0);
      tick();
      check_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule

// File: doc/exe_mem_pipe_reg.md
# exe_mem_pipe_reg

Parametrised EXE→MEM pipeline register with a configurable store-value forwarding mux, an explicit valid bit, flush (bubble insertion) and freeze (stall) control. During a freeze it captures the forwarded store value in a shadow register, because later-stage forwarding sources keep advancing while this stage holds. It sits between the execute stage and the memory stage of the core. It also keeps a saturating stall-cycle counter for performance monitoring.

## Interface
- DATA_W, 32, width of pc, alu_result, st_val and every forwarding source
- DEST_W, 5, width of destination register index
- NUM_FWD, 2, number of forwarding sources (≥1)
- SEL_W, $clog2(NUM_FWD+1), store-value selector width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- freeze  in  1  hold stage contents
- flush  in  1  squash the incoming instruction, insert bubble; overrides freeze
- valid_in  in  1  incoming instruction valid
- wb_en_in, mem_r_en_in, mem_w_en_in  in  1 each  control bits
- pc_in  in  DATA_W  instruction PC
- alu_result_in  in  DATA_W  ALU result / memory address
- st_val_in  in  DATA_W  store value from the register file
- dest_in  in  DEST_W  destination register
- st_val_sel  in  SEL_W  0 = st_val_in; k in 1..NUM_FWD = fwd_data slice k-1
- fwd_data  in  NUM_FWD*DATA_W  forwarding sources; slice k-1 = bits [k*DATA_W-1:(k-1)*DATA_W]
- valid, wb_en, mem_r_en, mem_w_en  out  1 each  registered
- pc, alu_result, st_val  out  DATA_W  registered
- dest  out  DEST_W  registered
- stall_cnt  out  CNT_W  count of frozen cycles

## Operation
- chosen = st_val_in if st_val_sel==0 or st_val_sel>NUM_FWD, otherwise fwd_data slice (st_val_sel-1).
- Internal registers: shadow (DATA_W) and shadow_vld (1).
- The priority order at each rising clk edge is flush > freeze > load.
- Flush:
  - valid, wb_en, mem_r_en and mem_w_en go to 0.
  - pc, alu_result, st_val and dest go to 0.
  - shadow_vld goes to 0.
  - stall_cnt is unchanged.
- Freeze (flush=0):
  - All outputs hold.
  - If shadow_vld==0: shadow←chosen, shadow_vld←1.
  - If shadow_vld==1: shadow holds.
  - stall_cnt increments, saturating at all-ones.
- Load (flush=0, freeze=0):
  - All outputs take their *_in values; valid←valid_in.
  - st_val←(shadow_vld ? shadow : chosen).
  - shadow_vld←0.
- valid_in=0 on a load: control bits and data are still loaded as presented. Downstream qualifies on valid. The block does not gate the enables.
- stall_cnt is cleared only by rst and never wraps.

## Timing
- Latency: inputs appear on outputs one clk edge after a load cycle.
- No combinational path from any input to any output.
- Reset: on rst assertion, with no clock required, every output, shadow, shadow_vld and stall_cnt go to 0. The first load takes effect at the first rising edge after rst deasserts.
- Reset mid-freeze discards shadow. After release, a load uses the live chosen value.
- Freeze for N cycles, then release: st_val equals chosen as sampled on the first frozen edge. Later changes on fwd_data or st_val_sel are ignored until release.
- Freeze and flush in the same cycle: flush wins. No shadow capture, and stall_cnt does not increment.
- Freeze for exactly one cycle: shadow is captured on that edge and used on the following load edge.
- st_val_sel changes during a freeze after capture: no effect.

## Test plan
- Load, defaults: after rst, apply pc_in=0x40, alu_result_in=0x1234, st_val_in=0xAA, dest_in=7, wb_en_in=1, valid_in=1, sel=0 → one edge later pc=0x40, alu_result=0x1234, st_val=0xAA, dest=7, wb_en=1, valid=1.
- Forwarding select: fwd_data slice0=0x11, slice1=0x22; sel=2 → st_val=0x22. sel=1 → st_val=0x11. sel=3 with NUM_FWD=2 → st_val=st_val_in.
- Stall capture:
  - Stimulus: sel=1, freeze=1 for 3 edges while slice0 steps 0x100, 0x200, 0x300; then freeze=0 with slice0=0x400.
  - Response: outputs hold during the freeze. The load edge gives st_val=0x100. stall_cnt rises by 3.
- Flush: flush=1 together with freeze=1 while wb_en=1, mem_w_en=1 → next edge valid=0, all enables 0, data 0, stall_cnt unchanged. The next load with sel=1 uses the live slice0.
- Async reset: mid-freeze with shadow valid and outputs nonzero, pulse rst between edges → all outputs and stall_cnt are 0 before the next edge. The following load uses live chosen, not the old shadow.
- Saturation: with CNT_W=4, hold freeze for 20 edges → stall_cnt=15 and stays at 15.
